// File: rtl/riscv_mem_access_pkg.sv
// Shared widths, FSM encoding and small helpers for the MEM-stage data access block.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package riscv_mem_access_pkg;

  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2,
    MEM_DONE = 2'd3
  } mem_state_e;

  // Word accesses only: any nonzero byte offset is a misaligned access.
  function automatic logic is_misaligned(input logic [1:0] byte_off);
    return byte_off != 2'b00;
  endfunction

endpackage

// File: rtl/riscv_mem_access.sv
// MEM stage: issues word loads/stores on a req/gnt/rvalid bus and registers the MEM/WB fields.
// Latency: 1 cycle for non-memory/misaligned ops, 3+ cycles for bus accesses (input to wb_valid_o).
// Backpressure: stall_o holds upstream while an access is being issued or awaited; bus timeouts abort with err_o.
module riscv_mem_access
  import riscv_mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  input  logic                  data_re_i,
  input  logic                  data_we_i,
  input  logic [REG_W-1:0]      alu_res_i,
  input  logic [REG_W-1:0]      wdata_i,
  input  logic [REG_ADDR_W-1:0] rd_idx_i,
  input  logic                  rd_we_i,
  output logic                  stall_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [REG_W-1:0]      mem_addr_o,
  output logic [REG_W-1:0]      mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [REG_W-1:0]      mem_rdata_i,
  output logic                  wb_valid_o,
  output logic [REG_ADDR_W-1:0] wb_rd_idx_o,
  output logic                  wb_rd_we_o,
  output logic [REG_W-1:0]      wb_data_o,
  output logic                  err_o
);

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              to_flag_q;
  logic              we_q;
  logic [REG_W-1:0]  addr_q, wdata_q, rdata_q;

  logic mem_op, mis, mem_go, cnt_last, capture, timeout_hit, wb_err, wb_load;

  assign mem_op   = in_valid_i & (data_re_i | data_we_i);
  assign mis      = is_misaligned(alu_res_i[1:0]);
  assign mem_go   = mem_op & ~mis;
  assign cnt_last = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  assign stall_o     = (state_q == MEM_REQ) | (state_q == MEM_WAIT) | ((state_q == MEM_IDLE) & mem_go);
  assign mem_req_o   = (state_q == MEM_REQ);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= MEM_IDLE;
    else        state_q <= state_d;
  end

  // Next state; a real bus response in the final counted cycle beats the timeout.
  always_comb begin
    state_d     = state_q;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      MEM_IDLE: if (mem_go) state_d = MEM_REQ;
      MEM_REQ: begin
        if (mem_gnt_i && we_q) begin
          state_d = MEM_DONE;
        end else if (mem_gnt_i && mem_rvalid_i) begin
          capture = 1'b1;
          state_d = MEM_DONE;
        end else if (mem_gnt_i) begin
          state_d = MEM_WAIT;
        end else if (cnt_last) begin
          timeout_hit = 1'b1;
          state_d     = MEM_DONE;
        end
      end
      MEM_WAIT: begin
        if (mem_rvalid_i) begin
          capture = 1'b1;
          state_d = MEM_DONE;
        end else if (cnt_last) begin
          timeout_hit = 1'b1;
          state_d     = MEM_DONE;
        end
      end
      MEM_DONE: state_d = MEM_IDLE;
      default:  state_d = MEM_IDLE;
    endcase
  end

  // Access context: latched on issue so the bus sees stable values; timeout counter and flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      we_q      <= 1'b0;
      cnt_q     <= '0;
      to_flag_q <= 1'b0;
    end else begin
      if ((state_q == MEM_IDLE) && mem_go) begin
        addr_q    <= {alu_res_i[REG_W-1:2], 2'b00};
        wdata_q   <= wdata_i;
        we_q      <= data_we_i;
        rdata_q   <= '0;
        cnt_q     <= '0;
        to_flag_q <= 1'b0;
      end else if ((state_q == MEM_REQ) || (state_q == MEM_WAIT)) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (capture)     rdata_q   <= mem_rdata_i;
      if (timeout_hit) to_flag_q <= 1'b1;
    end
  end

  // The timeout flag and captured data only belong to the instruction retiring from DONE.
  assign wb_err  = (mem_op & mis) | ((state_q == MEM_DONE) & to_flag_q);
  assign wb_load = (state_q == MEM_DONE) & ~we_q;

  // MEM/WB register: fields load whenever an instruction leaves this stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_o  <= 1'b0;
      wb_rd_idx_o <= '0;
      wb_rd_we_o  <= 1'b0;
      wb_data_o   <= '0;
      err_o       <= 1'b0;
    end else begin
      wb_valid_o <= in_valid_i & ~stall_o;
      if (in_valid_i && !stall_o) begin
        wb_rd_idx_o <= rd_idx_i;
        wb_rd_we_o  <= rd_we_i & ~wb_err;
        wb_data_o   <= wb_load ? rdata_q : alu_res_i;
        err_o       <= wb_err;
      end
    end
  end

endmodule

// File: tb/tb_riscv_mem_access.sv
// Bench for riscv_mem_access: directed and random ops with a write-back scoreboard.
// Latency: checks input-to-wb_valid cycle counts for each access type.
// Backpressure: bus grant/rvalid delays are driven per op; a second instance covers timeouts.
module tb_riscv_mem_access;
  import riscv_mem_access_pkg::*;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
    logic [REG_W-1:0]      data;
    logic                  err;
    logic                  chk;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  in_valid_i, data_re_i, data_we_i, rd_we_i;
  logic [REG_W-1:0]      alu_res_i, wdata_i, mem_rdata_i;
  logic [REG_ADDR_W-1:0] rd_idx_i;
  logic                  mem_gnt_i, mem_rvalid_i;

  logic                  stall_o, mem_req_o, mem_we_o, wb_valid_o, wb_rd_we_o, err_o;
  logic [REG_W-1:0]      mem_addr_o, mem_wdata_o, wb_data_o;
  logic [REG_ADDR_W-1:0] wb_rd_idx_o;

  logic                  to_stall, to_req, to_we, to_wb_valid, to_wb_rd_we, to_err;
  logic [REG_W-1:0]      to_addr, to_wdata, to_wb_data;
  logic [REG_ADDR_W-1:0] to_wb_rd_idx;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  riscv_mem_access dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_i), .data_re_i(data_re_i),
    .data_we_i(data_we_i), .alu_res_i(alu_res_i), .wdata_i(wdata_i), .rd_idx_i(rd_idx_i),
    .rd_we_i(rd_we_i), .stall_o(stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .wb_valid_o(wb_valid_o),
    .wb_rd_idx_o(wb_rd_idx_o), .wb_rd_we_o(wb_rd_we_o), .wb_data_o(wb_data_o), .err_o(err_o)
  );

  // Short-timeout instance whose bus never grants.
  riscv_mem_access #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut_to (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_i), .data_re_i(data_re_i),
    .data_we_i(data_we_i), .alu_res_i(alu_res_i), .wdata_i(wdata_i), .rd_idx_i(rd_idx_i),
    .rd_we_i(rd_we_i), .stall_o(to_stall), .mem_req_o(to_req), .mem_we_o(to_we),
    .mem_addr_o(to_addr), .mem_wdata_o(to_wdata), .mem_gnt_i(1'b0),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .wb_valid_o(to_wb_valid),
    .wb_rd_idx_o(to_wb_rd_idx), .wb_rd_we_o(to_wb_rd_we), .wb_data_o(to_wb_data), .err_o(to_err)
  );

  // Scoreboard: every write-back of the main instance must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && wb_valid_o) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wb_unexpected: got rd=%0d we=%0b data=%h err=%0b, required no write-back",
                 wb_rd_idx_o, wb_rd_we_o, wb_data_o, err_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (wb_rd_idx_o !== e.rd || wb_rd_we_o !== e.we || err_o !== e.err ||
            (e.chk && wb_data_o !== e.data)) begin
          bad++;
          $display("FAIL wb_fields: got rd=%0d we=%0b data=%h err=%0b, required rd=%0d we=%0b data=%h err=%0b",
                   wb_rd_idx_o, wb_rd_we_o, wb_data_o, err_o, e.rd, e.we, e.data, e.err);
        end
      end
    end
  end

  // Drives one instruction and a bus responder on the main instance until its write-back.
  // g: grant in the g-th request cycle (0-based); d: rvalid d cycles after grant unless same.
  task automatic do_op(input logic re, input logic we, input logic [REG_W-1:0] addr,
                       input logic [REG_W-1:0] wdata, input logic [REG_ADDR_W-1:0] rd,
                       input logic rdwe, input int g, input int d, input logic same,
                       input logic [REG_W-1:0] rdata,
                       output int lat, output int stall_n, output int req_n, output int req_bad);
    int  since;
    logic acc;
    lat = -1; stall_n = 0; req_n = 0; req_bad = 0; since = -1;
    in_valid_i = 1'b1; data_re_i = re; data_we_i = we; alu_res_i = addr;
    wdata_i = wdata; rd_idx_i = rd; rd_we_i = rdwe; mem_rdata_i = rdata;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (c > 0 && wb_valid_o) begin
        lat = c;
        break;
      end
      if (stall_o) stall_n++;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
      if (mem_req_o) begin
        if (mem_addr_o !== {addr[REG_W-1:2], 2'b00} || mem_we_o !== we || (we && mem_wdata_o !== wdata))
          req_bad++;
        if (req_n == g) begin
          mem_gnt_i = 1'b1;
          since = 0;
          if (same && !we) mem_rvalid_i = 1'b1;
        end
        req_n++;
      end else if (since >= 0) begin
        since++;
        if (!same && !we && since == d) mem_rvalid_i = 1'b1;
      end
      acc = !stall_o;
      @(posedge clk); #1;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
      if (acc) in_valid_i = 1'b0;
    end
    in_valid_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    in_valid_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall: got %0b, required 0", stall_o); end
    total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL reset_req: got %0b, required 0", mem_req_o); end
    total++; if (wb_valid_o !== 1'b0 || err_o !== 1'b0) begin
      bad++; $display("FAIL reset_wb: got valid=%0b err=%0b, required 0 0", wb_valid_o, err_o); end
    total++; if (mem_addr_o !== '0 || wb_data_o !== '0) begin
      bad++; $display("FAIL reset_data: got addr=%h wbdata=%h, required 0 0", mem_addr_o, wb_data_o); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_alu_op();
    int lat, st, rq, rb;
    exp_q.push_back('{rd: 5'd5, we: 1'b1, data: 32'h1234, err: 1'b0, chk: 1'b1});
    do_op(1'b0, 1'b0, 32'h1234, 32'h0, 5'd5, 1'b1, 0, 0, 1'b0, 32'h0, lat, st, rq, rb);
    total++; if (lat !== 1) begin bad++; $display("FAIL alu_latency: got %0d, required 1", lat); end
    total++; if (st !== 0 || rq !== 0) begin bad++; $display("FAIL alu_no_stall: got stall=%0d req=%0d, required 0 0", st, rq); end
  endtask

  task automatic test_store();
    int lat, st, rq, rb;
    exp_q.push_back('{rd: 5'd3, we: 1'b0, data: 32'h100, err: 1'b0, chk: 1'b1});
    do_op(1'b0, 1'b1, 32'h100, 32'hDEAD, 5'd3, 1'b0, 0, 0, 1'b0, 32'h0, lat, st, rq, rb);
    total++; if (lat !== 3) begin bad++; $display("FAIL store_latency: got %0d, required 3", lat); end
    total++; if (st !== 2) begin bad++; $display("FAIL store_stall: got %0d cycles, required 2", st); end
    total++; if (rq !== 1 || rb !== 0) begin bad++; $display("FAIL store_req: got req=%0d unstable=%0d, required 1 0", rq, rb); end
  endtask

  task automatic test_load_wait();
    int lat, st, rq, rb;
    exp_q.push_back('{rd: 5'd7, we: 1'b1, data: 32'hCAFEF00D, err: 1'b0, chk: 1'b1});
    do_op(1'b1, 1'b0, 32'h200, 32'h0, 5'd7, 1'b1, 2, 1, 1'b0, 32'hCAFEF00D, lat, st, rq, rb);
    total++; if (lat !== 6) begin bad++; $display("FAIL load_wait_latency: got %0d, required 6", lat); end
    total++; if (rq !== 3 || rb !== 0) begin bad++; $display("FAIL load_wait_req: got req=%0d unstable=%0d, required 3 0", rq, rb); end
    total++; if (st !== 5) begin bad++; $display("FAIL load_wait_stall: got %0d, required 5", st); end
  endtask

  task automatic test_load_same_cycle();
    int lat, st, rq, rb;
    exp_q.push_back('{rd: 5'd9, we: 1'b1, data: 32'h13579BDF, err: 1'b0, chk: 1'b1});
    do_op(1'b1, 1'b0, 32'h204, 32'h0, 5'd9, 1'b1, 0, 0, 1'b1, 32'h13579BDF, lat, st, rq, rb);
    total++; if (lat !== 3) begin bad++; $display("FAIL load_same_latency: got %0d, required 3", lat); end
    total++; if (rq !== 1) begin bad++; $display("FAIL load_same_req: got %0d, required 1", rq); end
  endtask

  task automatic test_misaligned();
    int lat, st, rq, rb;
    exp_q.push_back('{rd: 5'd2, we: 1'b0, data: 32'h0, err: 1'b1, chk: 1'b0});
    do_op(1'b1, 1'b0, 32'h102, 32'h0, 5'd2, 1'b1, 0, 0, 1'b0, 32'h0, lat, st, rq, rb);
    total++; if (lat !== 1) begin bad++; $display("FAIL mis_latency: got %0d, required 1", lat); end
    total++; if (rq !== 0 || st !== 0) begin bad++; $display("FAIL mis_no_req: got req=%0d stall=%0d, required 0 0", rq, st); end
  endtask

  task automatic test_random_mix();
    int lat, st, rq, rb, kind, g, d, lat_exp;
    logic same, re, we, rdwe;
    logic [REG_W-1:0] addr, wd, rdata;
    logic [REG_ADDR_W-1:0] rd;
    for (int i = 0; i < 10; i++) begin
      kind = $urandom_range(0, 3);
      g = $urandom_range(0, 3); d = $urandom_range(1, 3); same = 1'($urandom_range(0, 1));
      rd = REG_ADDR_W'($urandom); rdwe = 1'($urandom_range(0, 1));
      addr = $urandom; wd = $urandom; rdata = $urandom;
      re = 1'b0; we = 1'b0;
      case (kind)
        0: lat_exp = 1;
        1: begin addr[1:0] = 2'b00; we = 1'b1; re = 1'($urandom_range(0, 1)); lat_exp = g + 3; end
        2: begin addr[1:0] = 2'b00; re = 1'b1; lat_exp = same ? g + 3 : g + d + 3; end
        default: begin addr[1:0] = 2'($urandom_range(1, 3)); we = 1'b1; lat_exp = 1; end
      endcase
      if (kind == 2)
        exp_q.push_back('{rd: rd, we: rdwe, data: rdata, err: 1'b0, chk: 1'b1});
      else if (kind == 3)
        exp_q.push_back('{rd: rd, we: 1'b0, data: addr, err: 1'b1, chk: 1'b1});
      else
        exp_q.push_back('{rd: rd, we: rdwe, data: addr, err: 1'b0, chk: 1'b1});
      do_op(re, we, addr, wd, rd, rdwe, g, d, same, rdata, lat, st, rq, rb);
      total++; if (lat !== lat_exp) begin bad++; $display("FAIL mix_latency[%0d] kind=%0d: got %0d, required %0d", i, kind, lat, lat_exp); end
      total++; if (rb !== 0) begin bad++; $display("FAIL mix_req_stable[%0d]: got %0d unstable cycles, required 0", i, rb); end
    end
  endtask

  task automatic test_timeout();
    int lat, rq, late_wb;
    logic e, w;
    logic acc;
    pulse_reset();
    lat = -1; rq = 0; e = 1'b0; w = 1'b1; late_wb = 0;
    in_valid_i = 1'b1; data_re_i = 1'b1; data_we_i = 1'b0; alu_res_i = 32'h300;
    rd_idx_i = 5'd4; rd_we_i = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c > 0 && to_wb_valid) begin
        lat = c; e = to_err; w = to_wb_rd_we;
        break;
      end
      if (to_req) rq++;
      acc = !to_stall;
      @(posedge clk); #1;
      if (acc) in_valid_i = 1'b0;
    end
    in_valid_i = 1'b0;
    total++; if (rq !== 4) begin bad++; $display("FAIL timeout_req_cycles: got %0d, required 4", rq); end
    total++; if (lat !== 6) begin bad++; $display("FAIL timeout_latency: got %0d, required 6", lat); end
    total++; if (e !== 1'b1 || w !== 1'b0) begin bad++; $display("FAIL timeout_err: got err=%0b we=%0b, required 1 0", e, w); end
    @(posedge clk); #1;
    mem_rvalid_i = 1'b1;
    @(posedge clk); #1;
    mem_rvalid_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (to_wb_valid || to_req) late_wb++;
    end
    total++; if (late_wb !== 0) begin bad++; $display("FAIL timeout_late_resp: got %0d active cycles, required 0", late_wb); end
    @(posedge clk); #1;
    pulse_reset();
  endtask

  task automatic test_reset_mid_wait();
    int stray;
    stray = 0;
    in_valid_i = 1'b1; data_re_i = 1'b1; data_we_i = 1'b0; alu_res_i = 32'h400;
    rd_idx_i = 5'd6; rd_we_i = 1'b1;
    @(posedge clk); #1;
    mem_gnt_i = 1'b1;
    @(posedge clk); #1;
    mem_gnt_i = 1'b0;
    @(negedge clk);
    total++; if (stall_o !== 1'b1 || mem_req_o !== 1'b0 || mem_addr_o !== 32'h400) begin
      bad++; $display("FAIL wait_state: got stall=%0b req=%0b addr=%h, required 1 0 400", stall_o, mem_req_o, mem_addr_o); end
    rst_n = 1'b0; in_valid_i = 1'b0;
    #1;
    total++; if ({stall_o, mem_req_o, mem_we_o, mem_addr_o, wb_valid_o, wb_rd_we_o, err_o} !== '0) begin
      bad++; $display("FAIL mid_reset_outputs: got stall=%0b req=%0b addr=%h wbv=%0b err=%0b, required all 0",
                      stall_o, mem_req_o, mem_addr_o, wb_valid_o, err_o); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0BAD0BAD;
    @(posedge clk); #1;
    mem_rvalid_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (wb_valid_o || stall_o || mem_req_o) stray++;
    end
    total++; if (stray !== 0) begin bad++; $display("FAIL stray_rvalid: got %0d active cycles, required 0", stray); end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid_i = 1'b0; data_re_i = 1'b0; data_we_i = 1'b0; rd_we_i = 1'b0;
    alu_res_i = '0; wdata_i = '0; rd_idx_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    mem_rdata_i = '0;
    @(posedge clk); #1;
    test_reset();
    test_alu_op();
    test_store();
    test_load_wait();
    test_load_same_cycle();
    test_misaligned();
    test_random_mix();
    test_timeout();
    test_reset_mid_wait();
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL wb_missing: got %0d pending, required 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
